// File: rtl/xbee_pkg.sv
// Shared types and constants for the XBee transmit scheduler.
// The optional parity slot is enabled by defining XBEE_TX_PARITY_EN.
package xbee_pkg;

    localparam int XBEE_DATA_W   = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after `pointer`, wrapping
// modulo NUM_REQ. Purely combinational; `en` low forces an all-zero grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, pointer} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbee_tx_sched.sv
// Round-robin shared UART transmitter (8N1, optional even parity via
// XBEE_TX_PARITY_EN) that also sequences the external baud tick generator.
module xbee_tx_sched
    import xbee_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [XBEE_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tick,
    output logic                           baud_en,
    output logic                           baud_rst,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [XBEE_DATA_W-1:0] shift_q, shift_d;
`ifdef XBEE_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic [XBEE_DATA_W-1:0] sel_byte;

    // Gating with rst keeps req_ready silent while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .pointer   (ptr_q),
        .en        ((state_q == ST_IDLE) && !rst),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = arb_grant;
    assign grant_id  = grant_id_q;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_byte = sel_byte | req_data[i*XBEE_DATA_W +: XBEE_DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef XBEE_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef XBEE_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef XBEE_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        tx         = 1'b1;
        baud_en    = 1'b1;
        baud_rst   = 1'b0;
        busy       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // Generator held in reset so the next frame starts on a clean phase.
                baud_en  = 1'b0;
                baud_rst = 1'b1;
                busy     = 1'b0;
                if (|arb_grant) begin
                    shift_d    = sel_byte;
                    grant_id_d = arb_idx;
                    ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`ifdef XBEE_TX_PARITY_EN
                    parity_d   = ^sel_byte;
`endif
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'(XBEE_DATA_W - 1)) begin
                        bit_cnt_d = '0;
`ifdef XBEE_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef XBEE_TX_PARITY_EN
            ST_PARITY: begin
                tx = parity_q;
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                baud_en  = 1'b0;
                baud_rst = 1'b1;
                busy     = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xbee_tx_sched.sv
// Directed bench for xbee_tx_sched with a T=4 baud generator model and a
// scoreboard of expected (grant_id, byte) frames; honours XBEE_TX_PARITY_EN.
module tb_xbee_tx_sched;

    localparam int T  = 4;
    localparam int NR = 4;
`ifdef XBEE_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [31:0]   req_data = '0;
    logic [NR-1:0] req_ready;
    logic          tick = 1'b0;
    logic          baud_en, baud_rst, tx, busy;
    logic [1:0]    grant_id;

    logic [2:0]    bcnt = '0;
    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            waited;

    xbee_tx_sched #(.NUM_REQ(NR), .STOP_BITS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tick      (tick),
        .baud_en   (baud_en),
        .baud_rst  (baud_rst),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Baud generator: registered tick every T+1 enabled clocks, holds when disabled.
    always @(posedge clk) begin
        if (baud_rst) begin
            bcnt <= '0;
            tick <= 1'b0;
        end else if (baud_en) begin
            if (bcnt == 3'(T)) begin
                bcnt <= '0;
                tick <= 1'b1;
            end else begin
                bcnt <= bcnt + 3'd1;
                tick <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(output int w);
        w = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                w = i;
                break;
            end
        end
        n_cmp++;
        assert (w != 0) else begin
            n_err++;
            $error("FAIL start_timeout: observed no start bit expected one within 200 cycles");
        end
    endtask

    // Receives one frame sample by sample and compares against the scoreboard head.
    task automatic recv_frame(input logic [NR-1:0] valid_after, input bit b2b);
        int   w;
        exp_t e;
        wait_start(w);
        req_valid = valid_after;
        if (w == 0) return;
        if (b2b) check("idle_gap", w, 1);
        e.id   = '0;
        e.data = '0;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_pop: observed unexpected frame expected none");
        end
        if (sb.size() != 0) e = sb.pop_front();
        check("ready_in_frame", req_ready, 0);
        check("grant_id", grant_id, e.id);
        check("busy_start", busy, 1);
        check("baud_en_start", baud_en, 1);
        repeat (5) @(negedge clk);
        check("start_last", tx, 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("bit%0d_first", j), tx, e.data[j]);
            repeat (4) @(negedge clk);
            check($sformatf("bit%0d_last", j), tx, e.data[j]);
        end
        if (HAS_PAR) begin
            @(negedge clk);
            check("parity_first", tx, ^e.data);
            repeat (4) @(negedge clk);
            check("parity_last", tx, ^e.data);
        end
        @(negedge clk);
        check("stop_first", tx, 1);
        repeat (4) @(negedge clk);
        check("stop_last_busy", busy, 1);
        check("stop_last_tx", tx, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_tx", tx, 1);
        check("idle_baud_rst", baud_rst, 1);
        check("idle_grant_hold", grant_id, e.id);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state with every requester valid.
        rst       = 1'b1;
        req_valid = '1;
        req_data  = 32'h11223344;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_baud_rst", baud_rst, 1);
        check("rst_baud_en", baud_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);

        // Single byte 0xA5 from requester 2.
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h00A50000;
        #1;
        check("single_ready", req_ready, 4'b0100);
        push(2'd2, 8'hA5);
        recv_frame(4'b0000, 1'b0);

        // All four valid continuously: grants 0,1,2,3,0 back to back.
        do_reset();
        req_data  = 32'hC35A960F;
        req_valid = 4'b1111;
        push(2'd0, 8'h0F);
        push(2'd1, 8'h96);
        push(2'd2, 8'h5A);
        push(2'd3, 8'hC3);
        push(2'd0, 8'h0F);
        recv_frame(4'b1111, 1'b0);
        recv_frame(4'b1111, 1'b1);
        recv_frame(4'b1111, 1'b1);
        recv_frame(4'b1111, 1'b1);
        recv_frame(4'b0000, 1'b1);

        // Requester 1 drops while 0 sends; 2 goes next, then 1 on reassert.
        do_reset();
        req_data  = 32'h00E7183C;
        req_valid = 4'b0111;
        push(2'd0, 8'h3C);
        push(2'd2, 8'hE7);
        push(2'd1, 8'h18);
        recv_frame(4'b0100, 1'b0);
        recv_frame(4'b0010, 1'b1);
        recv_frame(4'b0000, 1'b1);

        // Asynchronous reset during data bit 3, then a clean retry.
        req_data  = 32'h34000000;
        req_valid = 4'b1000;
        wait_start(waited);
        check("abort_grant_id", grant_id, 3);
        repeat (23) @(negedge clk);
        check("abort_bit3", tx, 0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_baud_en", baud_en, 0);
        check("abort_baud_rst", baud_rst, 1);
        check("abort_ready", req_ready, 0);
        check("abort_grant_rst", grant_id, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(2'd3, 8'h34);
        recv_frame(4'b0000, 1'b0);

`ifdef XBEE_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0.
        do_reset();
        req_data  = 32'h00000007;
        req_valid = 4'b0001;
        push(2'd0, 8'h07);
        recv_frame(4'b0000, 1'b0);
        req_data  = 32'h00000003;
        req_valid = 4'b0001;
        push(2'd0, 8'h03);
        recv_frame(4'b0000, 1'b0);
`endif

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
